// File: rtl/phase_sequence_monitor.sv
// Downstream checker for the READY/SET/GO phase strobes: verifies one-hot
// encoding, phase order and hold time; counts rounds and flags GO entries.
module phase_sequence_monitor #(
  parameter int CNT_W    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             get_ready,
  input  logic             get_set,
  input  logic             get_going,
  input  logic             clear_err,
  output logic             go_start,
  output logic [CNT_W-1:0] round_cnt,
  output logic             seq_err,
  output logic [1:0]       err_code
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 2);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  typedef enum logic [2:0] {
    M_IDLE,
    M_READY,
    M_SET,
    M_GO,
    M_ERR
  } state_t;

  typedef enum logic [2:0] {
    PH_NONE,
    PH_R,
    PH_S,
    PH_G,
    PH_MULTI
  } phase_t;

  typedef enum logic [1:0] {
    E_NONE   = 2'b00,
    E_ONEHOT = 2'b01,
    E_ORDER  = 2'b10,
    E_STALL  = 2'b11
  } err_t;

  state_t            r_state;
  logic [HOLD_W-1:0] r_hold;
  logic              r_go_start;
  logic [CNT_W-1:0]  r_round_cnt;
  logic              r_seq_err;
  err_t              r_err_code;

  phase_t            w_phase;
  state_t            w_next_state;
  logic [HOLD_W-1:0] w_next_hold;
  logic              w_repeat;
  logic              w_go_set;
  logic              w_round_inc;
  logic              w_clear;
  err_t              w_fault;

  always_comb begin
    w_phase = PH_MULTI;
    unique case ({get_ready, get_set, get_going})
      3'b000:  w_phase = PH_NONE;
      3'b100:  w_phase = PH_R;
      3'b010:  w_phase = PH_S;
      3'b001:  w_phase = PH_G;
      default: w_phase = PH_MULTI;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_next_hold  = r_hold;
    w_repeat     = 1'b0;
    w_go_set     = 1'b0;
    w_round_inc  = 1'b0;
    w_clear      = 1'b0;
    w_fault      = E_NONE;

    unique case (r_state)
      M_IDLE: begin
        unique case (w_phase)
          PH_NONE: ;
          PH_R: begin
            w_next_state = M_READY;
            w_next_hold  = HOLD_W'(1);
          end
          PH_MULTI: w_fault = E_ONEHOT;
          default:  w_fault = E_ORDER;
        endcase
      end
      M_READY: begin
        unique case (w_phase)
          PH_R: w_repeat = 1'b1;
          PH_S: begin
            w_next_state = M_SET;
            w_next_hold  = HOLD_W'(1);
          end
          PH_MULTI: w_fault = E_ONEHOT;
          default:  w_fault = E_ORDER;
        endcase
      end
      M_SET: begin
        unique case (w_phase)
          PH_S: w_repeat = 1'b1;
          PH_G: begin
            w_next_state = M_GO;
            w_next_hold  = HOLD_W'(1);
            w_go_set     = 1'b1;
          end
          PH_MULTI: w_fault = E_ONEHOT;
          default:  w_fault = E_ORDER;
        endcase
      end
      M_GO: begin
        unique case (w_phase)
          PH_G: w_repeat = 1'b1;
          PH_R: begin
            w_next_state = M_READY;
            w_next_hold  = HOLD_W'(1);
            w_round_inc  = 1'b1;
          end
          PH_MULTI: w_fault = E_ONEHOT;
          default:  w_fault = E_ORDER;
        endcase
      end
      M_ERR: begin
        if (clear_err) begin
          w_next_state = M_IDLE;
          w_next_hold  = '0;
          w_clear      = 1'b1;
        end
      end
      default: w_next_state = M_IDLE;
    endcase

    // With the stall check disabled the hold count saturates instead of wrapping.
    if (w_repeat) begin
      if ((MAX_HOLD > 0) && (r_hold == HOLD_LIMIT)) begin
        w_fault = E_STALL;
      end else if (r_hold != '1) begin
        w_next_hold = r_hold + 1'b1;
      end
    end

    if (w_fault != E_NONE) begin
      w_next_state = M_ERR;
      w_next_hold  = '0;
      w_go_set     = 1'b0;
      w_round_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= M_IDLE;
      r_hold     <= '0;
      r_go_start <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_hold     <= w_next_hold;
      r_go_start <= w_go_set;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_round_cnt <= '0;
    end else if (w_round_inc && (r_round_cnt != '1)) begin
      r_round_cnt <= r_round_cnt + 1'b1;
    end
  end

  // Faults are only raised outside M_ERR, so the first cause is never overwritten.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_seq_err  <= 1'b0;
      r_err_code <= E_NONE;
    end else if (w_fault != E_NONE) begin
      r_seq_err  <= 1'b1;
      r_err_code <= w_fault;
    end else if (w_clear) begin
      r_seq_err  <= 1'b0;
      r_err_code <= E_NONE;
    end
  end

  assign go_start  = r_go_start;
  assign round_cnt = r_round_cnt;
  assign seq_err   = r_seq_err;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_phase_sequence_monitor.sv
// Randomised and directed bench for phase_sequence_monitor; three instances
// (default, stall check disabled, narrow counter) each tracked by a reference model.
module tb_phase_sequence_monitor;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic get_ready = 1'b0, get_set = 1'b0, get_going = 1'b0, clear_err = 1'b0;

  always #5 clk = ~clk;

  logic       go_a, err_a, go_b, err_b, go_c, err_c;
  logic [7:0] rc_a, rc_b;
  logic [3:0] rc_c;
  logic [1:0] code_a, code_b, code_c;

  phase_sequence_monitor #(.CNT_W(8), .MAX_HOLD(4)) u_dut_a (
    .clk(clk), .rstN(rstN), .get_ready(get_ready), .get_set(get_set),
    .get_going(get_going), .clear_err(clear_err), .go_start(go_a),
    .round_cnt(rc_a), .seq_err(err_a), .err_code(code_a));

  phase_sequence_monitor #(.CNT_W(8), .MAX_HOLD(0)) u_dut_b (
    .clk(clk), .rstN(rstN), .get_ready(get_ready), .get_set(get_set),
    .get_going(get_going), .clear_err(clear_err), .go_start(go_b),
    .round_cnt(rc_b), .seq_err(err_b), .err_code(code_b));

  phase_sequence_monitor #(.CNT_W(4), .MAX_HOLD(4)) u_dut_c (
    .clk(clk), .rstN(rstN), .get_ready(get_ready), .get_set(get_set),
    .get_going(get_going), .clear_err(clear_err), .go_start(go_c),
    .round_cnt(rc_c), .seq_err(err_c), .err_code(code_c));

  // last: position in the R(1) S(2) G(3) cycle, 0 before the first R
  typedef struct {
    int unsigned last;
    int unsigned run;
    bit          err;
    int unsigned code;
    bit          go;
    int unsigned rounds;
  } mdl_t;

  mdl_t        m[3];
  int unsigned mh[3]   = '{4, 0, 4};
  int unsigned cmax[3] = '{255, 255, 15};

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned go_cnt  = 0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n.last = 0; n.run = 0; n.err = 0; n.code = 0; n.go = 0; n.rounds = 0;
    return n;
  endfunction

  function automatic int unsigned succ(input int unsigned p);
    return (p == 0) ? 1 : (p % 3) + 1;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t cur, input logic [2:0] ph, input logic clr,
                                    input int unsigned max_hold, input int unsigned cnt_max);
    mdl_t n;
    int unsigned p;
    n = cur;
    n.go = 0;
    if (cur.err) begin
      if (clr) begin
        n.err = 0; n.code = 0; n.last = 0; n.run = 0;
      end
      return n;
    end
    case (ph)
      3'b000:  p = 0;
      3'b100:  p = 1;
      3'b010:  p = 2;
      3'b001:  p = 3;
      default: p = 4;
    endcase
    if (p == 4) begin
      n.err = 1; n.code = 1;
    end else if (p == cur.last) begin
      if (p != 0) begin
        if (max_hold != 0 && cur.run + 1 > max_hold) begin
          n.err = 1; n.code = 3;
        end else begin
          n.run = cur.run + 1;
        end
      end
    end else if (p == succ(cur.last)) begin
      n.last = p;
      n.run  = 1;
      if (p == 3) n.go = 1;
      if (cur.last == 3 && cur.rounds < cnt_max) n.rounds = cur.rounds + 1;
    end else begin
      n.err = 1; n.code = 2;
    end
    return n;
  endfunction

  task automatic cmp_dut(input string nm, input int k, input int unsigned go,
                         input int unsigned rc, input int unsigned er, input int unsigned cd);
    chk({nm, "_go_start"},  go, m[k].go);
    chk({nm, "_round_cnt"}, rc, m[k].rounds);
    chk({nm, "_seq_err"},   er, m[k].err);
    chk({nm, "_err_code"},  cd, m[k].err ? m[k].code : 0);
  endtask

  task automatic compare_all();
    cmp_dut("a", 0, go_a, rc_a, err_a, code_a);
    cmp_dut("b", 1, go_b, rc_b, err_b, code_b);
    cmp_dut("c", 2, go_c, rc_c, err_c, code_c);
  endtask

  task automatic drive(input logic [2:0] ph, input logic clr);
    {get_ready, get_set, get_going} = ph;
    clear_err = clr;
    @(posedge clk);
    for (int k = 0; k < 3; k++) m[k] = mdl_step(m[k], ph, clr, mh[k], cmax[k]);
    #1;
    compare_all();
    if (go_a) go_cnt++;
  endtask

  function automatic logic [2:0] ch2ph(input byte c);
    case (c)
      "R":     return 3'b100;
      "S":     return 3'b010;
      "G":     return 3'b001;
      "M":     return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  task automatic run_str(input string s);
    for (int unsigned i = 0; i < s.len(); i++) drive(ch2ph(s[i]), 1'b0);
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    {get_ready, get_set, get_going, clear_err} = 4'b0;
    repeat (2) @(posedge clk);
    #2 rstN = 1'b1;
    for (int k = 0; k < 3; k++) m[k] = mdl_reset();
    #1 compare_all();
  endtask

  initial begin
    int unsigned sel;
    int unsigned nxt;
    logic [2:0]  ph;

    do_reset();
    chk("reset_round_cnt", rc_a, 0);

    go_cnt = 0;
    run_str("NRSGRSGR");
    chk("nominal_go_pulses", go_cnt, 2);
    chk("nominal_round_cnt", rc_a, 2);
    chk("nominal_seq_err", err_a, 0);

    do_reset();
    run_str("NRG");
    chk("order_seq_err", err_a, 1);
    chk("order_err_code", code_a, 2);
    go_cnt = 0;
    run_str("RSG");
    chk("order_sticky_code", code_a, 2);
    chk("order_no_go", go_cnt, 0);

    do_reset();
    run_str("NRM");
    chk("onehot_err_code", code_a, 1);
    drive(3'b000, 1'b1);
    chk("onehot_clear_err", err_a, 0);
    chk("onehot_clear_code", code_a, 0);
    go_cnt = 0;
    run_str("RSG");
    chk("onehot_recover_go", go_cnt, 1);

    do_reset();
    run_str("RSSSS");
    chk("stall_hold4_ok", err_a, 0);
    run_str("S");
    chk("stall_err_code", code_a, 3);
    for (int i = 0; i < 95; i++) drive(3'b010, 1'b0);
    chk("stall_disabled_ok", err_b, 0);

    do_reset();
    run_str("N");
    for (int i = 0; i < 20; i++) run_str("RSG");
    run_str("R");
    chk("sat_round_cnt_c", rc_c, 15);
    chk("sat_round_cnt_a", rc_a, 20);
    chk("sat_seq_err_c", err_c, 0);

    do_reset();
    run_str("NRSGRSGRSGRSG");
    chk("async_pre_round_cnt", rc_a, 3);
    #2 rstN = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) m[k] = mdl_reset();
    chk("async_go_start", go_a, 0);
    chk("async_round_cnt", rc_a, 0);
    compare_all();
    repeat (2) @(posedge clk);
    #3 rstN = 1'b1;
    run_str("NRSGR");
    chk("async_restart_round_cnt", rc_a, 1);

    do_reset();
    for (int i = 0; i < 2000; i++) begin
      sel = $urandom_range(0, 99);
      nxt = (sel < 45) ? succ(m[0].last) : (m[0].last == 0 ? 1 : m[0].last);
      case (nxt)
        1:       ph = 3'b100;
        2:       ph = 3'b010;
        default: ph = 3'b001;
      endcase
      if (sel >= 75 && sel < 85) ph = 3'b000;
      else if (sel >= 85) ph = 3'($urandom_range(0, 7));
      drive(ph, ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
